// File: rtl/rst_seq_multi.sv
// Multi-channel reset sequencer: holds all channels in reset for MIN_ASSERT cycles,
// then releases the enabled channels one at a time in ascending index order.
module rst_seq_multi #(
   parameter int N_CH       = 4,
   parameter int DLY_W      = 16,
   parameter int MIN_ASSERT = 16,
   parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_soft_rst,
   input  logic             i_hold,
   input  logic [DLY_W-1:0] i_step_dly,
   input  logic [N_CH-1:0]  i_ch_en,
   output logic [N_CH-1:0]  o_rst,
   output logic             o_busy,
   output logic             o_done,
   output logic [CH_W-1:0]  o_cur_ch
);

   // One counter serves both the hold-off period and the step delay, so it
   // must cover whichever is longer.
   localparam int MA_W  = $clog2(MIN_ASSERT + 1);
   localparam int CNT_W = (DLY_W > MA_W) ? DLY_W : MA_W;
   localparam logic [CNT_W-1:0] MA_LAST = CNT_W'(MIN_ASSERT - 1);

   typedef enum logic [1:0] {ASSERT, STEP, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [DLY_W-1:0] step_q;
   logic [N_CH-1:0]  en_q;
   logic [CNT_W-1:0] step_ext;
   logic [CH_W:0]    first_nx;
   logic [CH_W:0]    step_nx;
   logic             latch;

   // Lowest set bit of mask at or above index from; MSB of result is the found flag.
   function automatic logic [CH_W:0] next_en(input logic [N_CH-1:0] mask, input int from);
      logic [CH_W:0] r;
      r = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i >= from)) r = {1'b1, CH_W'(i)};
      end
      return r;
   endfunction

   assign step_ext = CNT_W'(step_q);
   assign first_nx = next_en(i_ch_en, 0);
   assign step_nx  = next_en(en_q, int'(o_cur_ch) + 1);
   assign latch    = (state == ASSERT) && (cnt == MA_LAST) && !i_soft_rst && !i_rst;

   // Configuration snapshot taken once per sequence, at the end of the hold-off.
   always_ff @(posedge i_clk) begin
      if (latch) begin
         step_q <= i_step_dly;
         en_q   <= i_ch_en;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ASSERT;
         cnt      <= '0;
         o_rst    <= '1;
         o_busy   <= 1'b1;
         o_done   <= 1'b0;
         o_cur_ch <= '0;
      end else if (i_soft_rst) begin
         state    <= ASSERT;
         cnt      <= '0;
         o_rst    <= '1;
         o_busy   <= 1'b1;
         o_done   <= 1'b0;
         o_cur_ch <= '0;
      end else begin
         case (state)
            ASSERT: begin
               if (cnt == MA_LAST) begin
                  cnt <= '0;
                  if (first_nx[CH_W]) begin
                     state    <= STEP;
                     o_cur_ch <= first_nx[CH_W-1:0];
                  end else begin
                     state  <= DONE;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STEP: begin
               if (!i_hold) begin
                  if (cnt == step_ext) begin
                     o_rst[o_cur_ch] <= 1'b0;
                     cnt             <= '0;
                     // The last released index stays visible on o_cur_ch in DONE.
                     if (step_nx[CH_W]) begin
                        o_cur_ch <= step_nx[CH_W-1:0];
                     end else begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rst_seq_multi.sv
// Directed bench for rst_seq_multi: per-edge expectations derived from the release
// timing formulas are queued when a sequence starts and popped as the clock runs.
module tb_rst_seq_multi;

   localparam int MIN_A = 16;

   logic        clk;
   logic        i_rst;
   logic        i_soft_rst;
   logic        i_hold;
   logic [15:0] i_step_dly;
   logic [3:0]  i_ch_en;
   logic [3:0]  o_rst;
   logic        o_busy;
   logic        o_done;
   logic [1:0]  o_cur_ch;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         edge_n;
      logic [3:0] rst;
      logic       busy;
      logic       done;
      logic [1:0] cur;
   } exp_t;

   exp_t sb[$];

   rst_seq_multi #(.N_CH(4), .DLY_W(16), .MIN_ASSERT(MIN_A)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_soft_rst (i_soft_rst),
      .i_hold     (i_hold),
      .i_step_dly (i_step_dly),
      .i_ch_en    (i_ch_en),
      .o_rst      (o_rst),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_cur_ch   (o_cur_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [3:0] r, input logic b,
                            input logic d, input logic [1:0] c);
      chk({tag, ".rst"},  32'(o_rst),    32'(r));
      chk({tag, ".busy"}, 32'(o_busy),   32'(b));
      chk({tag, ".done"}, 32'(o_done),   32'(d));
      chk({tag, ".cur"},  32'(o_cur_ch), 32'(c));
   endtask

   task automatic do_reset(input string tag);
      i_rst      = 1'b1;
      i_soft_rst = 1'b0;
      i_hold     = 1'b0;
      tick();
      tick();
      chk_state(tag, 4'hF, 1'b1, 1'b0, 2'd0);
      i_rst = 1'b0;
   endtask

   // Runs n edges of a sequence starting at edge 1. Hold is sampled high on
   // edges hs..hs+hl-1 (hs=0: none); it shifts every release not yet reached.
   task automatic run_seq(input string tag, input logic [3:0] mask, input logic [15:0] step,
                          input int n, input int hs, input int hl);
      int   rel[4];
      int   k;
      int   last_rel;
      int   last_ch;
      exp_t x;
      k        = 0;
      last_rel = MIN_A;
      last_ch  = 0;
      for (int ch = 0; ch < 4; ch++) begin
         rel[ch] = 0;
         if (mask[ch]) begin
            rel[ch] = MIN_A + (k + 1) * (int'(step) + 1);
            if (hs > 0 && rel[ch] >= hs) rel[ch] += hl;
            k++;
            last_rel = rel[ch];
            last_ch  = ch;
         end
      end
      for (int e = 1; e <= n; e++) begin
         x.edge_n = e;
         x.rst    = 4'hF;
         for (int ch = 0; ch < 4; ch++)
            if (mask[ch] && e >= rel[ch]) x.rst[ch] = 1'b0;
         x.done = (e >= last_rel);
         x.busy = !x.done;
         x.cur  = 2'd0;
         if (e >= MIN_A) begin
            if (x.done) x.cur = 2'(last_ch);
            else begin
               for (int ch = 3; ch >= 0; ch--)
                  if (mask[ch] && rel[ch] > e) x.cur = 2'(ch);
            end
         end
         sb.push_back(x);
      end
      i_ch_en    = mask;
      i_step_dly = step;
      for (int e = 1; e <= n; e++) begin
         i_hold = (hs > 0 && e >= hs && e < hs + hl);
         tick();
         x = sb.pop_front();
         chk_state($sformatf("%s@e%0d", tag, x.edge_n), x.rst, x.busy, x.done, x.cur);
      end
      i_hold = 1'b0;
   endtask

   initial begin
      i_rst      = 1'b1;
      i_soft_rst = 1'b0;
      i_hold     = 1'b0;
      i_step_dly = 16'd3;
      i_ch_en    = 4'hF;
      #1;
      chk_state("rst_t0", 4'hF, 1'b1, 1'b0, 2'd0);

      // Full mask, step 3: releases at 20/24/28/32, then config changes in DONE are ignored.
      do_reset("rst_a");
      run_seq("full", 4'hF, 16'd3, 36, 0, 0);
      i_ch_en    = 4'h0;
      i_step_dly = 16'd0;
      for (int i = 0; i < 4; i++) tick();
      chk_state("full_done_hold", 4'h0, 1'b0, 1'b1, 2'd3);

      // Sparse mask, step 0.
      do_reset("rst_b");
      run_seq("sparse", 4'b1010, 16'd0, 22, 0, 0);

      // Soft reset pulse two cycles after channel 0 release, then full rerun.
      do_reset("rst_c");
      run_seq("pre_soft", 4'hF, 16'd3, 21, 0, 0);
      i_soft_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_state($sformatf("soft%0d", i), 4'hF, 1'b1, 1'b0, 2'd0);
      end
      i_soft_rst = 1'b0;
      run_seq("post_soft", 4'hF, 16'd3, 34, 0, 0);

      // Hold for five cycles while channel 1 is being timed.
      do_reset("rst_d");
      run_seq("hold", 4'hF, 16'd3, 40, 22, 5);

      // Async reset between edges, mid-STEP, then a full rerun.
      do_reset("rst_e");
      run_seq("pre_async", 4'hF, 16'd3, 26, 0, 0);
      #2 i_rst = 1'b1;
      #1;
      chk_state("async_rst", 4'hF, 1'b1, 1'b0, 2'd0);
      #1 i_rst = 1'b0;
      run_seq("post_async", 4'hF, 16'd3, 34, 0, 0);

      // Empty mask: done at the end of the hold-off, all channels stay in reset.
      do_reset("rst_f");
      run_seq("empty", 4'h0, 16'd3, 20, 0, 0);
      i_ch_en    = 4'hF;
      i_step_dly = 16'd0;
      for (int i = 0; i < 5; i++) tick();
      chk_state("empty_done_hold", 4'hF, 1'b0, 1'b1, 2'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rst_seq_multi.md
# rst_seq_multi

Parametrised multi-channel reset sequencer: the next-generation replacement for the single global reset/LED release path that testbenches drive through the global reset BFM. It holds N_CH downstream reset domains in reset for a guaranteed minimum time after power-on or soft reset. It then releases the enabled channels one at a time, in ascending index order, with a run-time programmable spacing. It sits between the board-level reset and the per-subsystem reset inputs, and reports sequence completion on a status output (LED-capable).

## Interface
- N_CH, 4, number of reset channels (1..32)
- DLY_W, 16, width of the inter-channel step delay
- MIN_ASSERT, 16, minimum cycles all channels are held after reset/soft reset (>=1)
- CH_W, $clog2(N_CH) (min 1), width of channel index
---
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_soft_rst  in  1  synchronous soft reset request, level-sensitive
- i_hold  in  1  freeze sequence progress while high
- i_step_dly  in  DLY_W  cycles between channel releases, minus one
- i_ch_en  in  N_CH  channel enable mask; disabled channels are never released
- o_rst  out  N_CH  per-channel reset, active-high, registered
- o_busy  out  1  sequence in progress
- o_done  out  1  all enabled channels released (LED drive)
- o_cur_ch  out  CH_W  index of the channel currently being timed

## Operation
- States: ASSERT, STEP, DONE.
- i_rst high (async): state=ASSERT, cnt=0, o_rst=all 1, o_busy=1, o_done=0, o_cur_ch=0.
- ASSERT:
  - cnt increments each cycle.
  - When cnt reaches MIN_ASSERT-1, latch i_step_dly into step_q and i_ch_en into en_q.
  - On that edge, go to STEP with cnt=0 and cur_ch=lowest enabled index.
  - If en_q==0, go directly to DONE.
- STEP:
  - If i_hold=1: cnt and cur_ch hold.
  - Otherwise: if cnt==step_q, clear o_rst[cur_ch], set cnt=0, and advance cur_ch to the next enabled index above it.
  - If no enabled index remains, go to DONE (o_done=1, o_busy=0) on the same edge.
  - Otherwise cnt++.
- DONE: outputs stable. o_rst bits of disabled channels stay 1.
- i_soft_rst=1 in any state: on the next edge, state=ASSERT, cnt=0, o_rst=all 1, o_done=0, o_busy=1. While it stays high, cnt is held at 0, so MIN_ASSERT counts from its deassertion.
- Priority: i_rst > i_soft_rst > i_hold > normal progress.
- i_step_dly and i_ch_en changes after the latch point have no effect until the next ASSERT exit.
- i_hold has no effect in ASSERT or DONE.

## Timing
- Edge 1 is the first rising edge with i_rst low.
- Channel k (k-th enabled channel, 0-based) sees o_rst fall at edge MIN_ASSERT + (k+1)*(step_q+1).
- o_done rises on the same edge as the last enabled channel's release.
- step_q=0 gives one release per cycle.
- step_q at its maximum (2^DLY_W-1) gives 2^DLY_W cycles per channel; the counter never wraps.
- All-disabled mask: o_done rises at edge MIN_ASSERT.
- Soft reset: o_rst all 1 one cycle after the first sampled i_soft_rst=1. The sequence restarts, with edge 1 being the first edge sampling i_soft_rst=0.
- Each i_hold=1 cycle in STEP delays all subsequent releases by one cycle.
- o_cur_ch is valid in STEP only. It is 0 in ASSERT and holds the last released index in DONE.

## Test plan
- MIN_ASSERT=16, N_CH=4, step=3, mask=4'hF, release i_rst -> o_rst bits clear individually at edges 20, 24, 28, 32; o_done=1 at edge 32; o_busy=0 at edge 32.
- mask=4'b1010, step=0 -> o_rst[1] clears at edge 17 and o_rst[3] at edge 18; o_rst[0] and o_rst[2] stay 1; o_done at edge 18.
- Pulse i_soft_rst for 3 cycles, starting 2 cycles after o_rst[0] releases -> o_rst=4'hF one edge later; the release of o_rst[0] repeats at 20 edges after i_soft_rst falls; o_done low throughout.
- i_hold high for 5 cycles during the timing of channel 1 (step=3) -> releases of channels 1..3 shift to edges 29, 33, 37; channel 0 stays at edge 20.
- Assert i_rst mid-STEP, asynchronously between edges -> o_rst=all 1, o_done=0, o_busy=1 immediately with no clock; the full sequence reruns after release.
- mask=0 -> o_done=1 at edge 16 and o_rst stays all 1; then change i_step_dly and i_ch_en in DONE -> no output change.
